// File: rtl/scan_sequencer.sv
// scan_sequencer: steps a 2-bit select code for a 2-to-4 decoder.
// Continuous scanning (RUN) follows the en level; a single 4-step sweep
// (SWEEP) is started by a sweep_start pulse. Step period is div+1 cycles.
//
// Input priority on every edge: rst > load > sweep_start > en.
// All outputs come straight from flops; tick/wrap/done are single-cycle
// pulses that are only raised on an edge where the code actually steps.
// sweep_start and load are pulses: they act on the edge where they are seen
// high and carry no state afterwards (no request/acknowledge handshake).

module scan_sequencer #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sweep_start,
    input  logic             dir,
    input  logic [DIV_W-1:0] div,
    input  logic             load,
    input  logic [1:0]       load_val,
    output logic             sel_hi,
    output logic             sel_lo,
    output logic             tick,
    output logic             wrap,
    output logic             done,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        SWEEP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;

    logic [1:0]       code;
    logic [1:0]       code_n;
    logic [DIV_W-1:0] pcnt;
    logic [DIV_W-1:0] pcnt_n;
    logic [1:0]       step_cnt;
    logic [1:0]       step_cnt_n;
    logic             tick_n;
    logic             wrap_n;
    logic             done_n;

    // Step decision helpers. div is compared live, so lowering div below
    // the running prescaler count forces a step on the very next edge.
    logic             step_due;
    logic [1:0]       code_step;
    logic             wrap_hit;

    // Prescaler terminal test and the code the next step would present
    always_comb begin
        step_due  = (pcnt >= div);
        code_step = dir ? (code - 2'd1) : (code + 2'd1);
        wrap_hit  = dir ? (code_step == 2'd3) : (code_step == 2'd0);
    end

    // Next-state and next-datapath logic; every target defaults to hold/idle
    always_comb begin
        state_n    = state;
        code_n     = code;
        pcnt_n     = pcnt;
        step_cnt_n = step_cnt;
        tick_n     = 1'b0;
        wrap_n     = 1'b0;
        done_n     = 1'b0;

        if (load) begin
            // Load overrides stepping and start requests but keeps the state.
            // Inside a sweep it restarts the 4-step count from the new code.
            code_n = load_val;
            pcnt_n = '0;
            if (state == SWEEP) begin
                step_cnt_n = 2'd0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (sweep_start) begin
                        state_n    = SWEEP;
                        pcnt_n     = '0;
                        step_cnt_n = 2'd0;
                    end else if (en) begin
                        state_n = RUN;
                        pcnt_n  = '0;
                    end
                end

                RUN: begin
                    if (sweep_start) begin
                        state_n    = SWEEP;
                        pcnt_n     = '0;
                        step_cnt_n = 2'd0;
                    end else if (!en) begin
                        // Code is held so the decoder output stays static
                        state_n = IDLE;
                        pcnt_n  = '0;
                    end else if (step_due) begin
                        code_n = code_step;
                        pcnt_n = '0;
                        tick_n = 1'b1;
                        wrap_n = wrap_hit;
                    end else begin
                        pcnt_n = pcnt + 1'b1;
                    end
                end

                SWEEP: begin
                    // en and repeated sweep_start are ignored until the
                    // fourth step returns the code to its starting value.
                    if (step_due) begin
                        code_n     = code_step;
                        pcnt_n     = '0;
                        tick_n     = 1'b1;
                        wrap_n     = wrap_hit;
                        step_cnt_n = step_cnt + 2'd1;
                        if (step_cnt == 2'd3) begin
                            done_n  = 1'b1;
                            state_n = IDLE;
                        end
                    end else begin
                        pcnt_n = pcnt + 1'b1;
                    end
                end

                default: begin
                    state_n = IDLE;
                    pcnt_n  = '0;
                end
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Datapath and registered outputs; reset discards any pending step
    always_ff @(posedge clk) begin
        if (rst) begin
            code     <= 2'd0;
            pcnt     <= '0;
            step_cnt <= 2'd0;
            tick     <= 1'b0;
            wrap     <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            code     <= code_n;
            pcnt     <= pcnt_n;
            step_cnt <= step_cnt_n;
            tick     <= tick_n;
            wrap     <= wrap_n;
            done     <= done_n;
            busy     <= (state_n != IDLE);
        end
    end

    // Code bits map directly onto the decoder inputs (i0 = MSB, i1 = LSB)
    always_comb begin
        sel_hi = code[1];
        sel_lo = code[0];
    end

endmodule
